// File: rtl/alien_pkg.sv
// Shared constants and types for the alien sprite driver: screen geometry, sprite size and
// the movement FSM state encoding.
package alien_pkg;

    typedef logic [10:0] coord_t;

    localparam int unsigned SpriteCols   = 13;
    localparam int unsigned SpriteRows   = 10;
    localparam int unsigned SpriteScale  = 4;
    localparam int unsigned ObjectWidth  = SpriteCols * SpriteScale;
    localparam int unsigned ObjectHeight = SpriteRows * SpriteScale;
    localparam int unsigned ScreenW      = 640;
    localparam int unsigned BottomY      = 440;

    typedef enum logic [2:0] {
        StMoveRight,
        StMoveLeft,
        StDropThenLeft,
        StDropThenRight,
        StLanded,
        StDead
    } alien_move_t;

endpackage

// File: rtl/frame_step_timer.sv
// Counts enabled frames and emits a one-cycle step pulse every FRAMES_PER_STEP frames.
// The pulse coincides with the startOfFrame cycle that completes the count.
module frame_step_timer #(
    parameter int unsigned FRAMES_PER_STEP = 30
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic enable,
    output logic step
);

    localparam int unsigned CntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            advance;

    assign advance = startOfFrame && enable;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (advance) begin
            if (cnt_q == CntLast) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alien_rect_driver.sv
// Positions one alien sprite, moves it on a frame-synchronous schedule and produces the
// registered inside/offset signals that address the sprite bitmap ROM.
module alien_rect_driver
    import alien_pkg::*;
#(
    parameter int unsigned OBJECT_WIDTH    = ObjectWidth,
    parameter int unsigned OBJECT_HEIGHT   = ObjectHeight,
    parameter int unsigned SCREEN_W        = ScreenW,
    parameter int unsigned BOTTOM_Y        = BottomY,
    parameter int unsigned START_X         = 32,
    parameter int unsigned START_Y         = 32,
    parameter int unsigned STEP_X          = 4,
    parameter int unsigned STEP_Y          = 16,
    parameter int unsigned FRAMES_PER_STEP = 30
) (
    input  logic   clk,
    input  logic   resetN,
    input  logic   startOfFrame,
    input  coord_t pixelX,
    input  coord_t pixelY,
    input  logic   enable,
    input  logic   collision,
    output coord_t offsetX,
    output coord_t offsetY,
    output logic   InsideRectangle,
    output coord_t topLeftX,
    output coord_t topLeftY,
    output logic   alive,
    output logic   landed
);

    alien_move_t state_q, state_d;
    coord_t      x_q, x_d, y_q, y_d;
    coord_t      off_x_q, off_x_d, off_y_q, off_y_d;
    logic        inside_q, inside_d;
    logic        step;
    logic [11:0] y_drop;
    logic [11:0] px, py, tx, ty;

    frame_step_timer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_timer (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (enable),
        .step        (step)
    );

    assign alive  = (state_q != StDead);
    assign landed = (state_q == StLanded);

    // Collision outranks a coincident step; LANDED and DEAD are terminal until reset.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        y_drop  = {1'b0, y_q} + 12'(STEP_Y);
        if (collision && state_q != StLanded && state_q != StDead) begin
            state_d = StDead;
        end else if (step) begin
            case (state_q)
                StMoveRight: begin
                    if ({1'b0, x_q} + 12'(OBJECT_WIDTH + STEP_X) > 12'(SCREEN_W)) begin
                        state_d = StDropThenLeft;
                    end else begin
                        x_d = x_q + 11'(STEP_X);
                    end
                end
                StMoveLeft: begin
                    if (x_q < 11'(STEP_X)) begin
                        state_d = StDropThenRight;
                    end else begin
                        x_d = x_q - 11'(STEP_X);
                    end
                end
                StDropThenLeft, StDropThenRight: begin
                    y_d = y_drop[10:0];
                    if (y_drop + 12'(OBJECT_HEIGHT) >= 12'(BOTTOM_Y)) begin
                        state_d = StLanded;
                    end else if (state_q == StDropThenLeft) begin
                        state_d = StMoveLeft;
                    end else begin
                        state_d = StMoveRight;
                    end
                end
                default: ;
            endcase
        end
    end

    // 12-bit compares so topLeft + size cannot wrap past 2047.
    always_comb begin
        px       = {1'b0, pixelX};
        py       = {1'b0, pixelY};
        tx       = {1'b0, x_q};
        ty       = {1'b0, y_q};
        inside_d = alive && (px >= tx) && (px < tx + 12'(OBJECT_WIDTH))
                         && (py >= ty) && (py < ty + 12'(OBJECT_HEIGHT));
        off_x_d  = inside_d ? (pixelX - x_q) : '0;
        off_y_d  = inside_d ? (pixelY - y_q) : '0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= StMoveRight;
            x_q      <= 11'(START_X);
            y_q      <= 11'(START_Y);
            inside_q <= 1'b0;
            off_x_q  <= '0;
            off_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            inside_q <= inside_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
        end
    end

    assign offsetX         = off_x_q;
    assign offsetY         = off_y_q;
    assign InsideRectangle = inside_q;
    assign topLeftX        = x_q;
    assign topLeftY        = y_q;

endmodule
